// File: rtl/mem_bank_param_if.sv
// Write/read port bundle for mem_bank_param: requester drives the master side,
// the memory bank implements the slave side.
interface mem_bank_param_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [BE_W-1:0]   wr_be;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              init_busy;
   logic              addr_err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy, addr_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, init_busy, addr_err
   );
endinterface

// File: rtl/mem_bank_param.sv
// Byte-writable single-clock memory bank with a post-reset clear sequence,
// write-first read forwarding and out-of-range access flagging.
module mem_bank_param #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16
) (
   input  logic             clk,
   input  logic             rst,
   mem_bank_param_if.slave  bus
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned AW1   = ADDR_W + 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] init_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              run_c;
   logic              wr_ok_c;
   logic              rd_ok_c;
   logic              wr_go_c;
   logic [DATA_W-1:0] rd_word_c;

   // Range checks carry one extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
   assign run_c   = (state == RUN);
   assign wr_ok_c = ({1'b0, bus.wr_addr} < AW1'(DEPTH));
   assign rd_ok_c = ({1'b0, bus.rd_addr} < AW1'(DEPTH));
   assign wr_go_c = run_c & bus.wr_en & wr_ok_c;

   // Write-first forwarding of enabled bytes when both ports hit the same word.
   always_comb begin
      rd_word_c = mem[bus.rd_addr[IDX_W-1:0]];
      for (int k = 0; k < BE_W; k++) begin
         if (wr_go_c && (bus.wr_addr == bus.rd_addr) && bus.wr_be[k]) begin
            rd_word_c[8*k +: 8] = bus.wr_data[8*k +: 8];
         end
      end
   end

   // Storage has no reset; only the INIT sweep clears it.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[init_cnt[IDX_W-1:0]] <= '0;
      end else if (wr_go_c) begin
         for (int k = 0; k < BE_W; k++) begin
            if (bus.wr_be[k]) begin
               mem[bus.wr_addr[IDX_W-1:0]][8*k +: 8] <= bus.wr_data[8*k +: 8];
            end
         end
      end
   end

   // Control FSM and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= INIT;
         init_cnt      <= '0;
         bus.rd_data   <= '0;
         bus.rd_valid  <= 1'b0;
         bus.addr_err  <= 1'b0;
         bus.init_busy <= 1'b1;
      end else begin
         bus.rd_valid <= 1'b0;
         bus.addr_err <= 1'b0;
         case (state)
            INIT: begin
               if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                  state         <= RUN;
                  bus.init_busy <= 1'b0;
               end else begin
                  init_cnt <= init_cnt + ADDR_W'(1);
               end
            end
            RUN: begin
               bus.rd_valid <= bus.rd_en;
               bus.addr_err <= (bus.wr_en & ~wr_ok_c) | (bus.rd_en & ~rd_ok_c);
               if (bus.rd_en) begin
                  bus.rd_data <= rd_ok_c ? rd_word_c : '0;
               end
            end
            default: begin
               state         <= INIT;
               bus.init_busy <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bank_param.sv
// Bench for mem_bank_param: a default-size instance tracked by a behavioural model
// and a DEPTH=12 instance exercised with directed out-of-range accesses.
module tb_mem_bank_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   chk_en   = 1'b0;

   mem_bank_param_if a ();
   mem_bank_param_if b ();

   mem_bank_param dut (
      .clk (clk),
      .rst (rst),
      .bus (a.slave)
   );

   mem_bank_param #(.ADDR_W(4), .DATA_W(16), .DEPTH(12)) dut12 (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the default instance: a word array plus a count of
   // clear cycles still owed after reset.
   localparam int M_DEPTH = 16;
   logic [15:0] m_mem [M_DEPTH];
   int          m_left = M_DEPTH;
   logic [15:0] m_rd_data = '0;
   logic        m_rd_valid = 1'b0;
   logic        m_addr_err = 1'b0;
   logic        m_busy = 1'b1;
   logic [15:0] m_tmp;
   bit          m_wr_ok, m_rd_ok;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_left = M_DEPTH; m_rd_data = '0; m_rd_valid = 1'b0; m_addr_err = 1'b0; m_busy = 1'b1;
      end else if (m_left > 0) begin
         m_mem[M_DEPTH - m_left] = '0;
         m_left--;
         m_rd_valid = 1'b0;
         m_addr_err = 1'b0;
         m_busy = (m_left > 0);
      end else begin
         m_wr_ok = int'(a.wr_addr) < M_DEPTH;
         m_rd_ok = int'(a.rd_addr) < M_DEPTH;
         m_rd_valid = a.rd_en;
         m_addr_err = (a.wr_en && !m_wr_ok) || (a.rd_en && !m_rd_ok);
         if (a.rd_en) begin
            m_tmp = m_rd_ok ? m_mem[a.rd_addr] : 16'h0000;
            if (m_rd_ok && a.wr_en && m_wr_ok && a.wr_addr == a.rd_addr) begin
               if (a.wr_be[0]) m_tmp[7:0]  = a.wr_data[7:0];
               if (a.wr_be[1]) m_tmp[15:8] = a.wr_data[15:8];
            end
            m_rd_data = m_tmp;
         end
         if (a.wr_en && m_wr_ok) begin
            if (a.wr_be[0]) m_mem[a.wr_addr][7:0]  = a.wr_data[7:0];
            if (a.wr_be[1]) m_mem[a.wr_addr][15:8] = a.wr_data[15:8];
         end
      end
   end

   // Every-cycle comparison of the default instance against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("m_rd_valid", 32'(a.rd_valid), 32'(m_rd_valid));
         chk("m_rd_data", 32'(a.rd_data), 32'(m_rd_data));
         chk("m_addr_err", 32'(a.addr_err), 32'(m_addr_err));
         chk("m_init_busy", 32'(a.init_busy), 32'(m_busy));
      end
   end

   task automatic idle();
      a.wr_en = 1'b0; a.rd_en = 1'b0; b.wr_en = 1'b0; b.rd_en = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_data"}, 32'(a.rd_data), 32'h0);
      chk({tag, "_rd_valid"}, 32'(a.rd_valid), 32'h0);
      chk({tag, "_addr_err"}, 32'(a.addr_err), 32'h0);
      chk({tag, "_init_busy"}, 32'(a.init_busy), 32'h1);
      chk({tag, "_b_init_busy"}, 32'(b.init_busy), 32'h1);
   endtask

   // Counts cycles with init_busy high after release; optional INIT-time traffic.
   task automatic count_init(input string tag, input bit noise, input int skip);
      int na = 0;
      int nb = 0;
      while (a.init_busy && na < 100) begin
         if (b.init_busy) nb++;
         if (noise) begin
            a.wr_en = 1'b1; a.wr_addr = 4'($urandom_range(15)); a.wr_data = 16'hFFFF; a.wr_be = 2'b11;
            a.rd_en = 1'b1; a.rd_addr = 4'($urandom_range(15));
            b.wr_en = b.init_busy; b.wr_addr = 4'($urandom_range(15)); b.wr_data = 16'hFFFF; b.wr_be = 2'b11;
            b.rd_en = b.init_busy; b.rd_addr = 4'($urandom_range(15));
         end
         @(negedge clk);
         na++;
      end
      idle();
      chk({tag, "_init_cycles"}, 32'(na), 32'(16 - skip));
      if (skip == 0) chk({tag, "_b_init_cycles"}, 32'(nb), 32'd12);
   endtask

   task automatic wr_a(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] be);
      a.wr_en = 1'b1; a.wr_addr = ad; a.wr_data = d; a.wr_be = be;
      @(negedge clk);
      a.wr_en = 1'b0;
   endtask

   task automatic rd_a(input logic [3:0] ad, input logic [15:0] exp, input string nm);
      a.rd_en = 1'b1; a.rd_addr = ad;
      @(negedge clk);
      a.rd_en = 1'b0;
      chk({nm, "_data"}, 32'(a.rd_data), 32'(exp));
      chk({nm, "_valid"}, 32'(a.rd_valid), 32'h1);
   endtask

   task automatic b_chk(input string nm, input logic err, input logic vld, input logic [15:0] d);
      chk({nm, "_err"}, 32'(b.addr_err), 32'(err));
      chk({nm, "_valid"}, 32'(b.rd_valid), 32'(vld));
      chk({nm, "_data"}, 32'(b.rd_data), 32'(d));
   endtask

   initial begin
      a.wr_en = 1'b0; a.wr_addr = '0; a.wr_data = '0; a.wr_be = '0; a.rd_en = 1'b0; a.rd_addr = '0;
      b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0; b.wr_be = '0; b.rd_en = 1'b0; b.rd_addr = '0;

      // Power-on reset, then INIT with both ports hammered.
      #1 rst = 1'b0;
      #1 chk_reset_outputs("por");
      chk_en = 1'b1;
      @(negedge clk); #1 rst = 1'b1;
      count_init("init1", 1'b1, 0);

      for (int i = 0; i < 16; i++) rd_a(4'(i), 16'h0000, "clear_rd");

      // Byte-enable merge on one word.
      wr_a(4'd3, 16'hABCD, 2'b11);
      wr_a(4'd3, 16'h1234, 2'b01);
      rd_a(4'd3, 16'hAB34, "be_merge");
      wr_a(4'd4, 16'h9999, 2'b00);
      rd_a(4'd4, 16'h0000, "be_none");

      // Same-cycle write/read of one address returns the written byte only.
      a.wr_en = 1'b1; a.wr_addr = 4'd5; a.wr_data = 16'h5A5A; a.wr_be = 2'b10;
      a.rd_en = 1'b1; a.rd_addr = 4'd5;
      @(negedge clk);
      idle();
      chk("wfirst_data", 32'(a.rd_data), 32'h5A00);
      chk("wfirst_valid", 32'(a.rd_valid), 32'h1);
      @(negedge clk);
      chk("hold_valid", 32'(a.rd_valid), 32'h0);
      chk("hold_data", 32'(a.rd_data), 32'h5A00);

      // Mixed traffic concentrated on a few addresses to force collisions.
      for (int i = 0; i < 40; i++) begin
         a.wr_en = 1'($urandom_range(1)); a.wr_addr = 4'($urandom_range(3));
         a.wr_data = 16'($urandom); a.wr_be = 2'($urandom_range(3));
         a.rd_en = 1'($urandom_range(1)); a.rd_addr = 4'($urandom_range(3));
         @(negedge clk);
      end
      idle();

      // Reset part-way through INIT.
      @(negedge clk); #1 rst = 1'b0;
      #1 chk_reset_outputs("rst1");
      @(negedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 7; i++) @(negedge clk);
      #1 rst = 1'b0;
      #1 chk_reset_outputs("mid_init");
      @(negedge clk); #1 rst = 1'b1;
      count_init("init2", 1'b0, 0);

      // Reset while a read is in flight in RUN.
      wr_a(4'd7, 16'hBEEF, 2'b11);
      rd_a(4'd7, 16'hBEEF, "pre_rst_rd");
      a.rd_en = 1'b1; a.rd_addr = 4'd7;
      #2 rst = 1'b0;
      #1 chk_reset_outputs("run_rst");
      idle();
      @(negedge clk); #1 rst = 1'b1;
      count_init("init3", 1'b0, 0);
      rd_a(4'd7, 16'h0000, "post_rst_rd");

      // Out-of-range handling on the DEPTH=12 instance.
      b.wr_en = 1'b1; b.wr_addr = 4'd11; b.wr_data = 16'h1111; b.wr_be = 2'b11;
      @(negedge clk);
      b_chk("b_wr11", 1'b0, 1'b0, 16'h0000);
      b.wr_addr = 4'd13; b.wr_data = 16'hFFFF;
      @(negedge clk);
      b.wr_en = 1'b0;
      b_chk("b_wr13", 1'b1, 1'b0, 16'h0000);
      b.rd_en = 1'b1; b.rd_addr = 4'd13;
      @(negedge clk);
      b.rd_en = 1'b0;
      b_chk("b_rd13", 1'b1, 1'b1, 16'h0000);
      @(negedge clk);
      b_chk("b_idle", 1'b0, 1'b0, 16'h0000);
      b.wr_en = 1'b1; b.wr_addr = 4'd12; b.rd_en = 1'b1; b.rd_addr = 4'd15;
      @(negedge clk);
      idle();
      b_chk("b_both_bad", 1'b1, 1'b1, 16'h0000);
      @(negedge clk);
      b_chk("b_single_pulse", 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 12; i++) begin
         b.rd_en = 1'b1; b.rd_addr = 4'(i);
         @(negedge clk);
         b_chk("b_scan", 1'b0, 1'b1, (i == 11) ? 16'h1111 : 16'h0000);
      end
      idle();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
